// File: rtl/register_set_pkg.sv
// Shared CPU register-file widths.
// Decode, ALU and writeback import these so operand widths agree.
package register_set_pkg;

  localparam int REG_DATA_W = 5;
  localparam int REG_ADDR_W = 2;
  localparam int REG_COUNT  = 1 << REG_ADDR_W;

endpackage

// File: rtl/register_set.sv
// 4x5 architectural register file: one sync write, two comb reads.
// Ports: Ra/Rb read addrs -> a/b; Wr/Wrd/reg_en write; clk; rst (sync, high).
module register_set
  import register_set_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic [ADDR_W-1:0] Ra,
  input  logic [ADDR_W-1:0] Rb,
  input  logic [ADDR_W-1:0] Wr,
  input  logic [DATA_W-1:0] Wrd,
  input  logic              reg_en,
  input  logic              clk,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  input  logic              rst
);

  localparam int N = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [N];

  // if (rst) keeps an X/Z reset from clearing the file in simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= '0;
      end
    end else if (reg_en) begin
      mem_q[Wr] <= Wrd;
    end
  end

  // No write bypass: reads see the pre-edge contents.
  assign a = mem_q[Ra];
  assign b = mem_q[Rb];

endmodule

// File: tb/tb_register_set.sv
// Self-checking bench for register_set.
// Vector table + scoreboard queue, plus comb-read sequences.
module tb_register_set;

  logic       clk;
  logic       rst;
  logic [1:0] Ra, Rb, Wr;
  logic [4:0] Wrd;
  logic       reg_en;
  logic [4:0] a, b;

  int checks;
  int fails;

  register_set dut (
    .Ra(Ra), .Rb(Rb), .Wr(Wr), .Wrd(Wrd),
    .reg_en(reg_en), .clk(clk),
    .a(a), .b(b), .rst(rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] wr;
    logic [4:0] wrd;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [4:0] ea;
    logic [4:0] eb;
  } vec_t;

  typedef struct {
    int         id;
    logic [4:0] ea;
    logic [4:0] eb;
  } exp_t;

  vec_t vecs [8];
  exp_t sb [$];

  task automatic chk(input string nm, input int id,
                     input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %b expected %b", nm, id, act, exp);
    end
  endtask

  task automatic apply(input int id, input vec_t v);
    exp_t e;
    @(negedge clk);
    rst = v.rst; reg_en = v.en; Wr = v.wr; Wrd = v.wrd;
    Ra = v.ra; Rb = v.rb;
    e.id = id; e.ea = v.ea; e.eb = v.eb;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; fails++;
      $display("FAIL scoreboard[%0d]: got empty queue expected entry", id);
    end else begin
      e = sb.pop_front();
      chk("vec_a", e.id, a, e.ea);
      chk("vec_b", e.id, b, e.eb);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst = 1'b0; reg_en = 1'b0;
    Ra = '0; Rb = '0; Wr = '0; Wrd = '0;

    //         rst en wr  wrd       ra rb  ea        eb
    vecs[0] = '{1, 1, 0, 5'b11011, 0, 1, 5'b00000, 5'b00000};
    vecs[1] = '{1, 0, 0, 5'b00000, 0, 1, 5'b00000, 5'b00000};
    vecs[2] = '{0, 1, 0, 5'b00111, 0, 1, 5'b00111, 5'b00000};
    vecs[3] = '{0, 1, 1, 5'b00110, 2, 1, 5'b00000, 5'b00110};
    vecs[4] = '{0, 0, 2, 5'b11111, 2, 0, 5'b00000, 5'b00111};
    vecs[5] = '{0, 0, 2, 5'b11111, 2, 2, 5'b00000, 5'b00000};
    vecs[6] = '{0, 1, 3, 5'b10101, 3, 3, 5'b10101, 5'b10101};
    vecs[7] = '{0, 1, 3, 5'b01001, 3, 0, 5'b01001, 5'b00111};

    for (int i = 0; i < 8; i++) apply(i, vecs[i]);

    // Reset priority over a same-edge write.
    apply(8, '{1, 1, 0, 5'b11011, 0, 3, 5'b00000, 5'b00000});

    // After reset every address reads zero, swept without a clock.
    @(negedge clk);
    rst = 1'b0; reg_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      Ra = 2'(i); Rb = 2'(3 - i);
      #1;
      chk("rst_a", i, a, 5'b00000);
      chk("rst_b", i, b, 5'b00000);
    end

    // Same-cycle read/write: old value before edge, new after.
    @(negedge clk);
    Ra = 2'd3; Rb = 2'd3; Wr = 2'd3; Wrd = 5'b10101; reg_en = 1'b1;
    #1;
    chk("pre_a", 0, a, 5'b00000);
    chk("pre_b", 0, b, 5'b00000);
    @(posedge clk);
    #1;
    chk("post_a", 0, a, 5'b10101);
    chk("post_b", 0, b, 5'b10101);

    // Full sweep: entry i = i+1, then every (Ra,Rb) pair.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      reg_en = 1'b1; Wr = 2'(i); Wrd = 5'(i + 1);
    end
    @(negedge clk);
    reg_en = 1'b0; Wrd = 5'b11111;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        Ra = 2'(i); Rb = 2'(j);
        #1;
        chk("sweep_a", i * 4 + j, a, 5'(i + 1));
        chk("sweep_b", i * 4 + j, b, 5'(j + 1));
      end
    end

    // Mid-sequence reset clears all prior writes.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      Ra = 2'(i); Rb = 2'(i);
      #1;
      chk("clr_a", i, a, 5'b00000);
      chk("clr_b", i, b, 5'b00000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
